avg: RTL and testbench
======================

Name: avg

Overview:
- Streaming sliding-window filter over 16-bit unsigned samples.
- Accepts one sample per clock and keeps the most recent 12.
- Once the window is full, outputs each cycle the window member closest to the window's integer average.
- Used as a datapath block that reduces a noisy sample stream to a representative value per sample.

Parameters:
- WIDTH, 16, sample and output width in bits (unsigned).
- DEPTH, 12, window length in samples. Fixed at 12; the divide-by-DEPTH datapath is constant-specific.

Ports:
- clk    input   1      rising-edge clock.
- reset  input   1      asynchronous, active-low reset.
- din    input   WIDTH  sample, captured on every rising clk edge while reset is high.
- ready  output  1      dout holds a valid result for a full window.
- dout   output  WIDTH  window member closest to the window average.

Behaviour:
- Reset (reset low, async): all window registers, fill count, sum, ready and dout go to 0. Outputs stay 0 while reset is held.
- Sampling:
  - The first rising edge with reset high captures sample s0.
  - Every subsequent edge captures the next sample; there is no valid/stall input.
- Window: shift register of the last 12 samples. A new sample evicts the oldest once 12 are held.
- Running sum: 20-bit unsigned, sum <= sum + new - evicted. No overflow: 12*65535 = 786420 < 2^20.
- Average: avg = floor(sum/12), a 16-bit integer. Division by a constant (multiply/shift or subtractive); truncation, no rounding.
- Selection:
  - Compute d_i = |w_i - avg| for all 12 entries and pick the entry with minimum d_i.
  - Tie between a value below avg and a value above avg: output the smaller value.
  - Duplicate values are allowed; all duplicates give the same result.
- Latency and handshake:
  - Let the edge that captures the 12th sample s11 be edge E.
  - At edge E+1, ready rises and dout presents the result for window s0..s11.
  - From then on, each edge updates dout with the result for the window ending at the sample captured one edge earlier.
- Steady state: ready remains 1 continuously until reset. Exactly one result per input sample after fill.
- Outputs dout and ready are registered; no combinational path from din.
- Reset mid-stream: asynchronously clears everything. Refill requires 12 new samples; old samples never contribute.
- Before fill (count < 12): ready = 0 and dout = 0; partial windows produce no output.

Optional Feature:
- Macro: AVG_OUT_EN.
- Defined:
  - Adds output port avg_out [WIDTH-1:0] carrying floor(sum/12) for the same window as dout.
  - Same registered timing as dout; resets to 0; 0 while ready = 0.
- Undefined: port absent. Core behaviour is identical either way.

Test Plan:
- Reset then din = 1,2,...,12 -> ready rises one cycle after sample 12 is captured; dout = 6 (sum 78, avg 6).
- Continue with din = 13 -> next dout = 7 (window 2..13, sum 90, avg 7).
- Twelve samples of 16'hFFFF -> sum 786420, avg 65535, dout = 65535, no overflow.
- Window of six 0s and six 10s -> avg 5, tie at distance 5 -> dout = 0 (smaller value wins).
- After 20 samples, pulse reset low mid-cycle -> ready and dout drop to 0 immediately; ready returns only one cycle after 12 fresh samples, and the result uses only post-reset data.
- 2000-sample random stream vs. golden model -> exactly 1989 results, first one at cycle 13 after reset release, all matching.

Source files
------------

// File: rtl/avg.sv
// avg: 12-sample sliding window; each cycle outputs the member nearest floor(sum/12).
// Optional macro AVG_OUT_EN adds the avg_out port carrying the registered window mean.
module avg #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic [WIDTH-1:0] dout
`ifdef AVG_OUT_EN
    ,
    output logic [WIDTH-1:0] avg_out
`endif
);

    localparam int SW = WIDTH + 4;

    logic [WIDTH-1:0] r_win [DEPTH];
    logic [3:0]       r_cnt;
    logic [SW-1:0]    r_sum;
    logic             r_ready;
    logic [WIDTH-1:0] r_dout;

    logic [WIDTH-1:0] w_avg;
    logic [4:0]       w_rem;
    logic [WIDTH-1:0] w_diff [DEPTH];
    logic [WIDTH-1:0] w_best_v;
    logic [WIDTH-1:0] w_best_d;

    // Restoring division by 12; sum < 12*2^WIDTH so the top nibble never yields a quotient bit.
    always_comb begin
        w_avg = '0;
        w_rem = {1'b0, r_sum[SW-1:WIDTH]};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            w_rem = {w_rem[3:0], r_sum[i]};
            if (w_rem >= 5'd12) begin
                w_rem    = w_rem - 5'd12;
                w_avg[i] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_diff[i] = (r_win[i] >= w_avg) ? (r_win[i] - w_avg) : (w_avg - r_win[i]);
        end
    end

    // Equal distances resolve to the smaller sample value.
    always_comb begin
        w_best_v = r_win[0];
        w_best_d = w_diff[0];
        for (int i = 1; i < DEPTH; i++) begin
            if ((w_diff[i] < w_best_d) ||
                ((w_diff[i] == w_best_d) && (r_win[i] < w_best_v))) begin
                w_best_v = r_win[i];
                w_best_d = w_diff[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_win[i] <= '0;
            end
            r_cnt   <= '0;
            r_sum   <= '0;
            r_ready <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_win[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_win[i] <= r_win[i-1];
            end
            // Oldest slot is still zero until the window fills, so subtracting it is harmless.
            r_sum <= r_sum + SW'(din) - SW'(r_win[DEPTH-1]);
            if (r_cnt != 4'(DEPTH)) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_ready <= 1'b1;
                r_dout  <= w_best_v;
            end
        end
    end

    assign ready = r_ready;
    assign dout  = r_dout;

`ifdef AVG_OUT_EN
    logic [WIDTH-1:0] r_avg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_avg <= '0;
        end else if (r_cnt == 4'(DEPTH)) begin
            r_avg <= w_avg;
        end
    end

    assign avg_out = r_avg;
`endif

endmodule

// File: tb/tb_avg.sv
// Bench for avg: constant vectors, corner sequences and a scoreboarded random stream.
// Builds with or without AVG_OUT_EN.
module tb_avg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] din = '0;
    logic        ready;
    logic [15:0] dout;
`ifdef AVG_OUT_EN
    logic [15:0] avg_out;
`endif

    avg dut (
        .clk     (clk),
        .reset   (reset),
        .din     (din),
        .ready   (ready),
        .dout    (dout)
`ifdef AVG_OUT_EN
        ,
        .avg_out (avg_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dout;
        logic [15:0] mean;
    } exp_t;

    typedef struct {
        logic [15:0] din;
        logic        exp_ready;
        logic [15:0] exp_dout;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_results = 0;
    int   n_steps = 0;
    int   first_step = -1;
    int   m_win[$];
    exp_t sb[$];
    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Golden model: the window as a queue, mean and nearest member by brute force.
    function automatic void capture(input logic [15:0] v);
        int   sum;
        int   mean;
        int   best_v;
        int   best_d;
        int   d;
        exp_t e;
        m_win.push_front(int'(v));
        if (m_win.size() > 12) void'(m_win.pop_back());
        if (m_win.size() == 12) begin
            sum = 0;
            foreach (m_win[i]) sum += m_win[i];
            mean   = sum / 12;
            best_v = 70000;
            best_d = 70000;
            foreach (m_win[i]) begin
                d = (m_win[i] > mean) ? m_win[i] - mean : mean - m_win[i];
                if (d < best_d || (d == best_d && m_win[i] < best_v)) begin
                    best_d = d;
                    best_v = m_win[i];
                end
            end
            e.dout = 16'(best_v);
            e.mean = 16'(mean);
            sb.push_back(e);
        end
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_results++;
            if (first_step < 0) first_step = n_steps;
            chk("sb_ready", ready, 1);
            chk("sb_dout", dout, e.dout);
`ifdef AVG_OUT_EN
            chk("sb_avg_out", avg_out, e.mean);
`endif
        end else begin
            chk("idle_ready", ready, 0);
            chk("idle_dout", dout, 0);
`ifdef AVG_OUT_EN
            chk("idle_avg_out", avg_out, 0);
`endif
        end
    endtask

    task automatic step(input logic [15:0] v);
        din = v;
        @(posedge clk);
        #1;
        n_steps++;
        check_out();
        capture(v);
    endtask

    // Entered 1 time unit after a rising edge; asserts reset mid-cycle.
    task automatic do_reset();
        #3;
        reset = 1'b0;
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_dout", dout, 0);
        m_win.delete();
        sb.delete();
        n_steps = 0;
        first_step = -1;
        n_results = 0;
        @(posedge clk);
        #1;
        chk("rst_hold_ready", ready, 0);
        chk("rst_hold_dout", dout, 0);
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 14; i++) begin
            vecs[i].din       = 16'(i + 1);
            vecs[i].exp_ready = (i >= 12);
            vecs[i].exp_dout  = '0;
        end
        vecs[12].exp_dout = 16'd6;
        vecs[13].exp_dout = 16'd7;

        do_reset();

        // Ramp 1..14: first result (6) one edge after sample 12, then 7.
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].din);
            chk("vec_ready", ready, vecs[i].exp_ready);
            chk("vec_dout", dout, vecs[i].exp_dout);
        end

        // Full-scale window: no sum overflow.
        do_reset();
        for (int i = 0; i < 12; i++) step(16'hFFFF);
        step(16'h0000);
        chk("max_dout", dout, 65535);
`ifdef AVG_OUT_EN
        chk("max_avg_out", avg_out, 65535);
`endif

        // Six 0s and six 10s: mean 5, equal distance, smaller value wins.
        do_reset();
        for (int i = 0; i < 12; i++) step((i % 2 == 0) ? 16'd0 : 16'd10);
        step(16'd10);
        chk("tie_dout", dout, 0);
`ifdef AVG_OUT_EN
        chk("tie_avg_out", avg_out, 5);
`endif

        // Reset mid-stream, then refill only from fresh samples.
        do_reset();
        for (int i = 0; i < 20; i++) step(16'($urandom_range(60000, 65535)));
        do_reset();
        for (int i = 0; i < 12; i++) step(16'($urandom_range(0, 100)));
        step(16'd50);
        chk("refill_ready", ready, 1);
        chk("refill_step", first_step, 13);

        // Long random stream against the model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (i % 3 == 0) step(16'($urandom()));
            else            step(16'($urandom_range(1000, 1040)));
        end
        step(16'd0);
        chk("rand_results", n_results, 1989);
        chk("rand_first_step", first_step, 13);
        chk("rand_sb_empty", sb.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
